alu_control_seq: RTL and testbench

ALU_CONTROL_SEQ -- requirements
Module: alu_control_seq

---
 rtl/alu_ctrl_pkg.sv | 38 +++
 rtl/alu_ctrl_decode.sv | 57 +++++
 rtl/alu_control_seq.sv | 116 +++++++++++
 tb/tb_alu_control_seq.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control sequencer: ALU operation selects, main-decoder
// operation classes, R-type funct codes and the sequencer state type.
package alu_ctrl_pkg;

  localparam logic [3:0] OpAnd     = 4'b0000;
  localparam logic [3:0] OpOr      = 4'b0001;
  localparam logic [3:0] OpNor     = 4'b0010;
  localparam logic [3:0] OpAdd     = 4'b0011;
  localparam logic [3:0] OpSub     = 4'b0100;
  localparam logic [3:0] OpLui     = 4'b0101;
  localparam logic [3:0] OpSll1    = 4'b0110;
  localparam logic [3:0] OpSrl1    = 4'b0111;
  localparam logic [3:0] OpPass    = 4'b1000;
  localparam logic [3:0] OpMulStep = 4'b1001;
  localparam logic [3:0] OpInvalid = 4'b1111;

  localparam logic [2:0] AluOpMem   = 3'b000;
  localparam logic [2:0] AluOpOr    = 3'b001;
  localparam logic [2:0] AluOpAnd   = 3'b010;
  localparam logic [2:0] AluOpAdd   = 3'b011;
  localparam logic [2:0] AluOpSub   = 3'b100;
  localparam logic [2:0] AluOpLui   = 3'b101;
  localparam logic [2:0] AluOpInv   = 3'b110;
  localparam logic [2:0] AluOpRType = 3'b111;

  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnNor  = 6'h27;
  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnJr   = 6'h08;
  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnMult = 6'h18;

  typedef enum logic [1:0] {StIdle, StShift, StMul} state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Zero-latency ALU control decode. Shifts and MULT decode to PASS here; the sequencer
// turns them into multi-cycle step sequences. MULT support depends on MULT_SEQ_EN.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [2:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [3:0] op_o,
  output logic       shift_o,
  output logic       shift_right_o,
  output logic       mult_o
);

  always_comb begin
    op_o          = OpInvalid;
    shift_o       = 1'b0;
    shift_right_o = 1'b0;
    mult_o        = 1'b0;
    unique case (alu_op_i)
      AluOpMem:   op_o = OpAdd;
      AluOpOr:    op_o = OpOr;
      AluOpAnd:   op_o = OpAnd;
      AluOpAdd:   op_o = OpAdd;
      AluOpSub:   op_o = OpSub;
      AluOpLui:   op_o = OpLui;
      AluOpInv:   op_o = OpInvalid;
      AluOpRType: begin
        case (funct_i)
          FnAnd: op_o = OpAnd;
          FnOr:  op_o = OpOr;
          FnNor: op_o = OpNor;
          FnAdd: op_o = OpAdd;
          FnSub: op_o = OpSub;
          FnJr:  op_o = OpPass;
          FnSll: begin
            op_o    = OpPass;
            shift_o = 1'b1;
          end
          FnSrl: begin
            op_o          = OpPass;
            shift_o       = 1'b1;
            shift_right_o = 1'b1;
          end
`ifdef MULT_SEQ_EN
          FnMult: begin
            op_o   = OpPass;
            mult_o = 1'b1;
          end
`endif
          default: op_o = OpInvalid;
        endcase
      end
      default: op_o = OpInvalid;
    endcase
  end

endmodule

// File: rtl/alu_control_seq.sv
// ALU control with a multi-cycle sequencer for shifts (one bit per step) and, when
// MULT_SEQ_EN is defined, a DATA_WIDTH-step multiply. Single-cycle ops decode directly.
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SHAMT_WIDTH = 5,
  parameter int unsigned CTRL_WIDTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Start,
  input  logic [2:0]             ALUOp,
  input  logic [5:0]             ALUFunction,
  input  logic [SHAMT_WIDTH-1:0] Shamt,
  output logic [CTRL_WIDTH-1:0]  ALUOperation,
  output logic                   StepAccumulate,
  output logic                   Busy,
  output logic                   Done
);

  localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            dir_right_q;
  logic            done_q;

  logic [3:0] dec_op;
  logic       dec_shift;
  logic       dec_right;
  logic       dec_mult;
  logic       launch_shift;
  logic       launch_mult;
  logic       in_idle;
  logic [3:0] op_sel;

  alu_ctrl_decode u_decode (
    .alu_op_i      (ALUOp),
    .funct_i       (ALUFunction),
    .op_o          (dec_op),
    .shift_o       (dec_shift),
    .shift_right_o (dec_right),
    .mult_o        (dec_mult)
  );

  assign in_idle      = (state_q == StIdle);
  // A zero shift is just a pass-through and never enters the sequencer.
  assign launch_shift = Start & dec_shift & (|Shamt);
`ifdef MULT_SEQ_EN
  assign launch_mult  = Start & dec_mult;
`else
  assign launch_mult  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      dir_right_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (launch_shift) begin
            state_q     <= StShift;
            cnt_q       <= CntW'(Shamt - SHAMT_WIDTH'(1));
            dir_right_q <= dec_right;
          end
`ifdef MULT_SEQ_EN
          else if (launch_mult) begin
            state_q <= StMul;
            cnt_q   <= CntW'(DATA_WIDTH - 1);
          end
`endif
        end
        StShift: begin
          if (cnt_q == '0) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
`ifdef MULT_SEQ_EN
        StMul: begin
          if (cnt_q == '0) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    op_sel = dec_op;
    unique case (state_q)
      StShift: op_sel = dir_right_q ? OpSrl1 : OpSll1;
      StMul:   op_sel = OpMulStep;
      default: op_sel = dec_op;
    endcase
  end

  assign ALUOperation   = CTRL_WIDTH'(op_sel);
  assign StepAccumulate = ~in_idle;
  // Gate the launch cycle with reset so Busy drops immediately while reset is low.
  assign Busy           = ~in_idle | (reset & (launch_shift | launch_mult));
  assign Done           = done_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// Self-checking bench for alu_control_seq: per-cycle expectations go through a scoreboard
// queue and are compared at the falling edge, plus asynchronous reset checks.
module tb_alu_control_seq;

  localparam logic [3:0] EAnd  = 4'b0000;
  localparam logic [3:0] EOr   = 4'b0001;
  localparam logic [3:0] ENor  = 4'b0010;
  localparam logic [3:0] EAdd  = 4'b0011;
  localparam logic [3:0] ESub  = 4'b0100;
  localparam logic [3:0] ELui  = 4'b0101;
  localparam logic [3:0] ESll1 = 4'b0110;
  localparam logic [3:0] ESrl1 = 4'b0111;
  localparam logic [3:0] EPass = 4'b1000;
  localparam logic [3:0] EMul  = 4'b1001;
  localparam logic [3:0] EInv  = 4'b1111;

  typedef struct packed {
    logic [3:0] op;
    logic       busy;
    logic       step;
    logic       done;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] alu_op;
  logic [5:0] funct;
  logic [4:0] shamt;
  logic [3:0] alu_operation;
  logic       step_acc;
  logic       busy;
  logic       done;

  exp_t sb[$];
  int   n_tests;
  int   n_fail;

  alu_control_seq dut (
    .clk            (clk),
    .reset          (reset),
    .Start          (start),
    .ALUOp          (alu_op),
    .ALUFunction    (funct),
    .Shamt          (shamt),
    .ALUOperation   (alu_operation),
    .StepAccumulate (step_acc),
    .Busy           (busy),
    .Done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs after the rising edge, queue the expectation, check at negedge.
  task automatic cyc(input logic st, input logic [2:0] op, input logic [5:0] fn,
                     input logic [4:0] sh, input logic [3:0] e_op, input logic e_busy,
                     input logic e_step, input logic e_done);
    exp_t e;
    @(posedge clk);
    #1;
    start  = st;
    alu_op = op;
    funct  = fn;
    shamt  = sh;
    sb.push_back('{op: e_op, busy: e_busy, step: e_step, done: e_done});
    @(negedge clk);
    e = sb.pop_front();
    check_eq("op",   32'(alu_operation), 32'(e.op));
    check_eq("busy", 32'(busy),          32'(e.busy));
    check_eq("step", 32'(step_acc),      32'(e.step));
    check_eq("done", 32'(done),          32'(e.done));
  endtask

  task automatic run_shift(input logic right, input int n, input logic perturb);
    logic [5:0] fn;
    logic [3:0] sop;
    fn  = right ? 6'h02 : 6'h00;
    sop = right ? ESrl1 : ESll1;
    if (n == 0) begin
      cyc(1'b1, 3'b111, fn, 5'd0, EPass, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 3'b111, 6'h20, 5'd0, EAdd, 1'b0, 1'b0, 1'b0);
    end else begin
      cyc(1'b1, 3'b111, fn, 5'(n), EPass, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= n; i++) begin
        if (perturb) cyc(i[0], 3'b111, 6'h24, 5'(n + 3), sop, 1'b1, 1'b1, 1'b0);
        else         cyc(1'b0, 3'b111, fn, 5'(n), sop, 1'b1, 1'b1, 1'b0);
      end
      if (perturb) cyc(1'b0, 3'b111, 6'h24, 5'd0, EAnd, 1'b0, 1'b0, 1'b1);
      else         cyc(1'b0, 3'b111, 6'h20, 5'd0, EAdd, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 3'b111, 6'h20, 5'd0, EAdd, 1'b0, 1'b0, 1'b0);
    end
  endtask

  logic [2:0] tbl_op  [14];
  logic [5:0] tbl_fn  [14];
  logic [3:0] tbl_exp [14];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    start   = 1'b0;
    alu_op  = 3'b000;
    funct   = 6'h00;
    shamt   = 5'd0;

    tbl_op = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110,
               3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111};
    tbl_fn = '{6'h11, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h20,
               6'h24, 6'h25, 6'h27, 6'h20, 6'h22, 6'h08, 6'h3f};
    tbl_exp = '{EAdd, EOr, EAnd, EAdd, ESub, ELui, EInv,
                EAnd, EOr, ENor, EAdd, ESub, EPass, EInv};

    // Outputs while held in reset: decode follows inputs, status low.
    #2;
    check_eq("rst_op",   32'(alu_operation), 32'(EAdd));
    check_eq("rst_busy", 32'(busy),          32'd0);
    check_eq("rst_step", 32'(step_acc),      32'd0);
    check_eq("rst_done", 32'(done),          32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Single-cycle decode, with Start asserted.
    for (int i = 0; i < 14; i++)
      cyc(1'b1, tbl_op[i], tbl_fn[i], 5'd7, tbl_exp[i], 1'b0, 1'b0, 1'b0);

    // Shift decoded without Start is decode only.
    cyc(1'b0, 3'b111, 6'h00, 5'd4, EPass, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 3'b111, 6'h20, 5'd4, EAdd, 1'b0, 1'b0, 1'b0);

    run_shift(1'b0, 3, 1'b0);
    run_shift(1'b1, 0, 1'b0);
    run_shift(1'b1, 31, 1'b0);
    run_shift(1'b0, 1, 1'b0);
    run_shift(1'b0, 4, 1'b1);

`ifdef MULT_SEQ_EN
    cyc(1'b1, 3'b111, 6'h18, 5'd0, EPass, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 32; i++)
      cyc(1'b0, 3'b111, 6'h18, 5'd0, EMul, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 3'b111, 6'h20, 5'd0, EAdd, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 3'b111, 6'h20, 5'd0, EAdd, 1'b0, 1'b0, 1'b0);
`else
    cyc(1'b1, 3'b111, 6'h18, 5'd0, EInv, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 3'b111, 6'h20, 5'd0, EAdd, 1'b0, 1'b0, 1'b0);
`endif

    // Reset in the middle of a Shamt=5 shift, during SHIFT cycle 2.
    cyc(1'b1, 3'b111, 6'h00, 5'd5, EPass, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 3'b111, 6'h00, 5'd5, ESll1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 3'b111, 6'h00, 5'd5, ESll1, 1'b1, 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_eq("mid_rst_busy", 32'(busy),          32'd0);
    check_eq("mid_rst_step", 32'(step_acc),      32'd0);
    check_eq("mid_rst_done", 32'(done),          32'd0);
    check_eq("mid_rst_op",   32'(alu_operation), 32'(EPass));
    @(posedge clk);
    @(negedge clk);
    check_eq("hold_rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 3'b111, 6'h20, 5'd5, EAdd, 1'b0, 1'b0, 1'b0);

    // Sequencer still works after the reset.
    run_shift(1'b1, 2, 1'b0);

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
